// File: rtl/ct_ifu_ind_btb_pkg.sv
// Shared types and default geometry for the multi-way indirect BTB target array.
package ct_ifu_ind_btb_pkg;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_DATA_W = 23;
  localparam int DEF_WAYS   = 2;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;
endpackage

// File: rtl/ct_ifu_ind_btb_way_ram.sv
// Behavioural single-port way RAM; dout updates only on read cycles and holds otherwise.
module ct_ifu_ind_btb_way_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 23,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              cen_b,
  input  logic              wen_b,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!cen_b) begin
      if (!wen_b) mem[index] <= din;
      else        dout       <= mem[index];
    end
  end
endmodule

// File: rtl/ct_ifu_ind_btb_multiway_array.sv
// N-way indirect BTB target array: shared-port way RAMs, clear sequencer, one-entry write buffer with read bypass.
module ct_ifu_ind_btb_multiway_array
  import ct_ifu_ind_btb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAYS   = DEF_WAYS,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   rd_vld,
  input  logic [IDX_W-1:0]       rd_index,
  output logic [WAYS*DATA_W-1:0] rd_dout,
  output logic                   rd_dout_vld,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [WAYS-1:0]        wr_way,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   inv_req,
  output logic                   busy
);
  localparam logic [IDX_W:0] CLR_LAST = (IDX_W+1)'(DEPTH-1);
  localparam logic [IDX_W:0] CLR_ONE  = (IDX_W+1)'(1);

  state_t            state;
  logic [IDX_W:0]    clr_cnt;
  logic              buf_vld;
  logic [IDX_W-1:0]  buf_index;
  logic [WAYS-1:0]   buf_way;
  logic [DATA_W-1:0] buf_data;
  logic [WAYS-1:0]   byp_way;
  logic [DATA_W-1:0] byp_data;
  logic              out_ok;

  logic              is_idle, rd_go, wr_acc;
  logic [WAYS-1:0]   ram_cen_b, ram_wen_b;
  logic [IDX_W-1:0]  ram_index;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout [WAYS];

  assign is_idle = (state == IDLE);
  assign busy    = ~is_idle;
  assign wr_rdy  = is_idle & ~(buf_vld & rd_vld);
  assign rd_go   = is_idle & rd_vld;
  assign wr_acc  = wr_vld & wr_rdy;

  // Unselected ways stay disabled on writes so their read latch keeps the last read value.
  always_comb begin
    ram_cen_b = '1;
    ram_wen_b = '1;
    ram_index = rd_index;
    ram_din   = wr_data;
    if (!is_idle) begin
      ram_cen_b = '0;
      ram_wen_b = '0;
      ram_index = clr_cnt[IDX_W-1:0];
      ram_din   = '0;
    end else if (rd_vld) begin
      ram_cen_b = '0;
    end else if (buf_vld) begin
      ram_cen_b = ~buf_way;
      ram_wen_b = ~buf_way;
      ram_index = buf_index;
      ram_din   = buf_data;
    end else if (wr_acc) begin
      ram_cen_b = ~wr_way;
      ram_wen_b = ~wr_way;
      ram_index = wr_index;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state       <= INIT;
      clr_cnt     <= '0;
      buf_vld     <= 1'b0;
      buf_index   <= '0;
      buf_way     <= '0;
      buf_data    <= '0;
      byp_way     <= '0;
      byp_data    <= '0;
      out_ok      <= 1'b0;
      rd_dout_vld <= 1'b0;
    end else begin
      rd_dout_vld <= rd_go;
      if (rd_go) begin
        out_ok   <= 1'b1;
        byp_way  <= (buf_vld && buf_index == rd_index) ? buf_way : '0;
        byp_data <= buf_data;
      end
      if (inv_req) begin
        state   <= INIT;
        clr_cnt <= '0;
        buf_vld <= 1'b0;
      end else if (!is_idle) begin
        buf_vld <= 1'b0;
        if (clr_cnt == CLR_LAST) begin
          state   <= IDLE;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + CLR_ONE;
        end
      end else if (wr_acc && (rd_vld || buf_vld)) begin
        buf_vld   <= 1'b1;
        buf_index <= wr_index;
        buf_way   <= wr_way;
        buf_data  <= wr_data;
      end else if (!rd_vld && buf_vld) begin
        buf_vld <= 1'b0;
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ct_ifu_ind_btb_way_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_ram (
      .clk   (forever_cpuclk),
      .cen_b (ram_cen_b[w]),
      .wen_b (ram_wen_b[w]),
      .index (ram_index),
      .din   (ram_din),
      .dout  (ram_dout[w])
    );
    assign rd_dout[w*DATA_W +: DATA_W] = !out_ok     ? '0 :
                                         byp_way[w] ? byp_data : ram_dout[w];
  end
endmodule

// File: tb/tb_ct_ifu_ind_btb_multiway_array.sv
// Directed bench: default 256x2 instance plus a 64x4 instance with a short modelled random stream.
module tb_ct_ifu_ind_btb_multiway_array;
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 256 x 2 instance
  logic        rd_vld, wr_vld, inv_req;
  logic [7:0]  rd_index, wr_index;
  logic [1:0]  wr_way;
  logic [22:0] wr_data;
  logic [45:0] rd_dout;
  logic        rd_dout_vld, wr_rdy, busy;

  // 64 x 4 instance
  logic        q_rd_vld, q_wr_vld, q_inv_req;
  logic [5:0]  q_rd_index, q_wr_index;
  logic [3:0]  q_wr_way;
  logic [22:0] q_wr_data;
  logic [91:0] q_rd_dout;
  logic        q_rd_dout_vld, q_wr_rdy, q_busy;

  ct_ifu_ind_btb_multiway_array u0 (
    .forever_cpuclk(clk), .cpurst_b(rst_b),
    .rd_vld(rd_vld), .rd_index(rd_index), .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_index(wr_index), .wr_way(wr_way), .wr_data(wr_data),
    .inv_req(inv_req), .busy(busy)
  );

  ct_ifu_ind_btb_multiway_array #(.DEPTH(64), .DATA_W(23), .WAYS(4)) u1 (
    .forever_cpuclk(clk), .cpurst_b(rst_b),
    .rd_vld(q_rd_vld), .rd_index(q_rd_index), .rd_dout(q_rd_dout), .rd_dout_vld(q_rd_dout_vld),
    .wr_vld(q_wr_vld), .wr_rdy(q_wr_rdy), .wr_index(q_wr_index), .wr_way(q_wr_way), .wr_data(q_wr_data),
    .inv_req(q_inv_req), .busy(q_busy)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [22:0] mem [64][4];
  logic [91:0] e;
  logic        mbuf, r, w, exp_rdy;
  logic [5:0]  ri, wi;
  logic [3:0]  wm;
  logic [22:0] wd;
  int          n, qn;

  initial begin
    rst_b = 1'b0;
    rd_vld = 0; wr_vld = 0; inv_req = 0; rd_index = 0; wr_index = 0; wr_way = 0; wr_data = 0;
    q_rd_vld = 0; q_wr_vld = 0; q_inv_req = 0; q_rd_index = 0; q_wr_index = 0; q_wr_way = 0; q_wr_data = 0;
    step(); step(); step();
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_wr_rdy", 128'(wr_rdy), 128'(0));
    chk("rst_rd_dout", 128'(rd_dout), 128'(0));
    chk("rst_rd_dout_vld", 128'(rd_dout_vld), 128'(0));
    chk("rst_q_busy", 128'(q_busy), 128'(1));

    rst_b = 1'b1;
    n = 0; qn = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (!busy && n == 0) n = i;
      if (!q_busy && qn == 0) qn = i;
      if (n != 0 && qn != 0) break;
    end
    chk("init_len_256", 128'(n), 128'(256));
    chk("init_len_64", 128'(qn), 128'(64));

    // Read after init
    rd_vld = 1; rd_index = 8'h5A;
    step(); rd_vld = 0;
    chk("rd5a_vld", 128'(rd_dout_vld), 128'(1));
    chk("rd5a_dout", 128'(rd_dout), 128'(0));
    step();
    chk("rd5a_vld_one_cycle", 128'(rd_dout_vld), 128'(0));

    // Direct write then read
    wr_vld = 1; wr_index = 8'h10; wr_way = 2'b10; wr_data = 23'h1ABCDE;
    #1 chk("wr1_rdy", 128'(wr_rdy), 128'(1));
    step(); wr_vld = 0;
    rd_vld = 1; rd_index = 8'h10;
    step(); rd_vld = 0;
    chk("wr1_read", 128'(rd_dout), 128'({23'h1ABCDE, 23'h0}));

    // A: same-cycle read and write to 0x10
    rd_vld = 1; rd_index = 8'h10;
    wr_vld = 1; wr_index = 8'h10; wr_way = 2'b01; wr_data = 23'h7;
    #1 chk("A_wr_rdy", 128'(wr_rdy), 128'(1));
    step();
    chk("A_old_data", 128'(rd_dout), 128'({23'h1ABCDE, 23'h0}));
    // B: bypass read, write blocked
    wr_index = 8'h30; wr_way = 2'b11; wr_data = 23'h55;
    #1 chk("B_wr_rdy", 128'(wr_rdy), 128'(0));
    step();
    chk("B_bypass", 128'(rd_dout), 128'({23'h1ABCDE, 23'h7}));
    // C, D: reads of another index keep the buffer stuck
    rd_index = 8'h20;
    #1 chk("C_wr_rdy", 128'(wr_rdy), 128'(0));
    step();
    chk("C_read20", 128'(rd_dout), 128'(0));
    #1 chk("D_wr_rdy", 128'(wr_rdy), 128'(0));
    step();
    // E: drop read, buffer drains and the pending write refills it
    rd_vld = 0;
    #1 chk("E_wr_rdy", 128'(wr_rdy), 128'(1));
    step(); wr_vld = 0;
    chk("E_no_vld", 128'(rd_dout_vld), 128'(0));
    // F: read 0x30 from buffer
    rd_vld = 1; rd_index = 8'h30;
    step(); rd_vld = 0;
    chk("F_bypass30", 128'(rd_dout), 128'({23'h55, 23'h55}));
    step();
    // H: 0x10 now from the array
    rd_vld = 1; rd_index = 8'h10;
    step(); rd_vld = 0;
    chk("H_array10", 128'(rd_dout), 128'({23'h1ABCDE, 23'h7}));
    step();
    chk("I_hold_dout", 128'(rd_dout), 128'({23'h1ABCDE, 23'h7}));
    chk("I_hold_vld", 128'(rd_dout_vld), 128'(0));
    rd_vld = 1; rd_index = 8'h30;
    step(); rd_vld = 0;
    chk("J_array30", 128'(rd_dout), 128'({23'h55, 23'h55}));

    // Flush
    chk("pre_inv_busy", 128'(busy), 128'(0));
    inv_req = 1;
    step(); inv_req = 0;
    chk("inv_busy", 128'(busy), 128'(1));
    chk("inv_wr_rdy", 128'(wr_rdy), 128'(0));
    rd_vld = 1; rd_index = 8'h10;
    step(); rd_vld = 0;
    chk("init_rd_ignored", 128'(rd_dout_vld), 128'(0));
    chk("init_dout_hold", 128'(rd_dout), 128'({23'h55, 23'h55}));
    for (int i = 0; i < 90; i++) step();
    chk("mid_sweep_busy", 128'(busy), 128'(1));
    inv_req = 1;
    step(); inv_req = 0;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk("reinv_len", 128'(n), 128'(256));
    rd_vld = 1; rd_index = 8'h10;
    step();
    chk("flushed10", 128'(rd_dout), 128'(0));
    rd_index = 8'h30;
    step(); rd_vld = 0;
    chk("flushed30", 128'(rd_dout), 128'(0));
    chk("flushed30_vld", 128'(rd_dout_vld), 128'(1));

    // 64 x 4 directed
    q_wr_vld = 1; q_wr_index = 6'h3F; q_wr_way = 4'b1001; q_wr_data = 23'h2AAAAA;
    step();
    q_wr_index = 6'h00; q_wr_way = 4'b0110; q_wr_data = 23'h1;
    step(); q_wr_vld = 0;
    q_rd_vld = 1; q_rd_index = 6'h3F;
    step();
    chk("q_read3f", 128'(q_rd_dout), 128'({23'h2AAAAA, 23'h0, 23'h0, 23'h2AAAAA}));
    q_rd_index = 6'h00;
    step();
    chk("q_read00", 128'(q_rd_dout), 128'({23'h0, 23'h1, 23'h1, 23'h0}));
    q_rd_index = 6'h3F;
    q_wr_vld = 1; q_wr_index = 6'h3F; q_wr_way = 4'b0010; q_wr_data = 23'h12345;
    step(); q_wr_vld = 0;
    chk("q_old3f", 128'(q_rd_dout), 128'({23'h2AAAAA, 23'h0, 23'h0, 23'h2AAAAA}));
    step(); q_rd_vld = 0;
    chk("q_byp3f", 128'(q_rd_dout), 128'({23'h2AAAAA, 23'h0, 23'h12345, 23'h2AAAAA}));
    step();

    // 64 x 4 random stream on indices 8..15 against a reference model
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) mem[i][k] = '0;
    mbuf = 1'b0;
    for (int i = 0; i < 80; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      ri = 6'(8 + $urandom_range(0, 7));
      wi = 6'(8 + $urandom_range(0, 7));
      wm = 4'($urandom_range(0, 15));
      wd = 23'($urandom);
      q_rd_vld = r; q_rd_index = ri;
      q_wr_vld = w; q_wr_index = wi; q_wr_way = wm; q_wr_data = wd;
      exp_rdy = !(mbuf && r);
      #1 chk("rnd_wr_rdy", 128'(q_wr_rdy), 128'(exp_rdy));
      for (int k = 0; k < 4; k++) e[k*23 +: 23] = mem[ri][k];
      if (w && exp_rdy) begin
        for (int k = 0; k < 4; k++)
          if (wm[k]) mem[wi][k] = wd;
        if (r || mbuf) mbuf = 1'b1;
      end else if (!r && mbuf) begin
        mbuf = 1'b0;
      end
      step();
      chk("rnd_rd_vld", 128'(q_rd_dout_vld), 128'(r));
      if (r) chk("rnd_rd_dout", 128'(q_rd_dout), 128'(e));
    end
    q_rd_vld = 0; q_wr_vld = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
